// File: rtl/schoolbook_mac_ctrl.sv
// Sequencer for negacyclic schoolbook multiplication acc = a * s in Z_(2^W)[x]/(x^N+1).
// Issues operand/accumulator reads, then drives the external MAC and writes the result one cycle later.
module schoolbook_mac_ctrl #(
  parameter int N     = 256,
  parameter int LOG2N = 8,
  parameter int W     = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             s_rd_en,
  output logic [LOG2N-1:0] s_rd_addr,
  input  logic [3:0]       s_rd_data,
  output logic             a_rd_en,
  output logic [LOG2N-1:0] a_rd_addr,
  input  logic [W-1:0]     a_rd_data,
  output logic             acc_rd_en,
  output logic [LOG2N-1:0] acc_rd_addr,
  input  logic [W-1:0]     acc_rd_data,
  output logic             acc_wr_en,
  output logic [LOG2N-1:0] acc_wr_addr,
  output logic [W-1:0]     acc_wr_data,
  output logic [W-1:0]     mac_ri,
  output logic [W-1:0]     mac_a,
  output logic [3:0]       mac_s,
  input  logic [W-1:0]     mac_result
);

  typedef enum logic [2:0] {IDLE, LOAD_S, RUN, DRAIN, DONE} state_t;

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  localparam logic [LOG2N:0]   NVAL = (LOG2N + 1)'(N);

  state_t           state_q, state_d;
  logic [LOG2N-1:0] i_q, i_d, j_q, j_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             s_rd_en_q, s_rd_en_d, a_rd_en_q, a_rd_en_d, acc_rd_en_q, acc_rd_en_d;
  logic [LOG2N-1:0] s_rd_addr_q, s_rd_addr_d, a_rd_addr_q, a_rd_addr_d;
  logic [LOG2N-1:0] acc_rd_addr_q, acc_rd_addr_d;
  logic             vld_p1_q, vld_p1_d, fwd_p1_q, fwd_p1_d;

  logic [3:0]       s_reg_q, s_reg_d;
  logic [LOG2N-1:0] k_p1_q, k_p1_d;
  logic             wrap_p1_q, wrap_p1_d, first_p1_q, first_p1_d;
  logic [W-1:0]     fwd_data_p1_q, fwd_data_p1_d;
  logic [W-1:0]     ri_p1;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE:   if (start) begin
                state_d = LOAD_S;
                i_d     = '0;
              end
      LOAD_S: begin
                state_d = RUN;
                j_d     = '0;
              end
      RUN:    if (j_q == LAST) begin
                j_d     = '0;
                i_d     = i_q + 1'b1;
                state_d = (i_q == LAST) ? DRAIN : LOAD_S;
              end else begin
                j_d = j_q + 1'b1;
              end
      DRAIN:  state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d        = (state_d != IDLE) && (state_d != DONE);
    done_d        = (state_d == DONE);
    s_rd_en_d     = (state_d == LOAD_S);
    s_rd_addr_d   = s_rd_en_d ? i_d : '0;
    a_rd_en_d     = (state_d == RUN);
    a_rd_addr_d   = a_rd_en_d ? j_d : '0;
    acc_rd_en_d   = a_rd_en_d;
    acc_rd_addr_d = a_rd_en_d ? (i_d + j_d) : '0;

    // Issue stage: capture what the compute stage needs one cycle later.
    vld_p1_d      = a_rd_en_q;
    k_p1_d        = acc_rd_addr_q;
    wrap_p1_d     = ({1'b0, i_q} + {1'b0, j_q}) >= NVAL;
    first_p1_d    = (i_q == '0);
    fwd_p1_d      = a_rd_en_q && vld_p1_q && (acc_rd_addr_q == k_p1_q);
    fwd_data_p1_d = acc_wr_data;
    // s_rd_data is valid only in the first RUN cycle; the previous row's last write still uses the old digit.
    s_reg_d       = (state_q == RUN && j_q == '0) ? s_rd_data : s_reg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      s_rd_en_q     <= 1'b0;
      s_rd_addr_q   <= '0;
      a_rd_en_q     <= 1'b0;
      a_rd_addr_q   <= '0;
      acc_rd_en_q   <= 1'b0;
      acc_rd_addr_q <= '0;
      vld_p1_q      <= 1'b0;
      fwd_p1_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      s_rd_en_q     <= s_rd_en_d;
      s_rd_addr_q   <= s_rd_addr_d;
      a_rd_en_q     <= a_rd_en_d;
      a_rd_addr_q   <= a_rd_addr_d;
      acc_rd_en_q   <= acc_rd_en_d;
      acc_rd_addr_q <= acc_rd_addr_d;
      vld_p1_q      <= vld_p1_d;
      fwd_p1_q      <= fwd_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    s_reg_q       <= s_reg_d;
    k_p1_q        <= k_p1_d;
    wrap_p1_q     <= wrap_p1_d;
    first_p1_q    <= first_p1_d;
    fwd_data_p1_q <= fwd_data_p1_d;
  end

  // Compute stage: outputs are gated by the stage valid so they read 0 whenever idle or in reset.
  always_comb begin
    ri_p1       = first_p1_q ? '0 : (fwd_p1_q ? fwd_data_p1_q : acc_rd_data);
    mac_ri      = vld_p1_q ? ri_p1 : '0;
    mac_a       = vld_p1_q ? a_rd_data : '0;
    mac_s       = vld_p1_q ? {s_reg_q[3] ^ wrap_p1_q, s_reg_q[2:0]} : 4'd0;
    acc_wr_en   = vld_p1_q;
    acc_wr_addr = vld_p1_q ? k_p1_q : '0;
    acc_wr_data = vld_p1_q ? mac_result : '0;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign s_rd_en     = s_rd_en_q;
  assign s_rd_addr   = s_rd_addr_q;
  assign a_rd_en     = a_rd_en_q;
  assign a_rd_addr   = a_rd_addr_q;
  assign acc_rd_en   = acc_rd_en_q;
  assign acc_rd_addr = acc_rd_addr_q;

endmodule

// File: tb/tb_schoolbook_mac_ctrl.sv
// Directed and randomised bench for schoolbook_mac_ctrl at N=4 with behavioural RAMs and MAC.
module tb_schoolbook_mac_ctrl;
  localparam int N = 4, LOG2N = 2, W = 13;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic busy, done, s_rd_en, a_rd_en, acc_rd_en, acc_wr_en;
  logic [LOG2N-1:0] s_rd_addr, a_rd_addr, acc_rd_addr, acc_wr_addr;
  logic [3:0] s_rd_data = '0, mac_s;
  logic [W-1:0] a_rd_data = '0, acc_rd_data = '0, acc_wr_data, mac_ri, mac_a, mac_result;

  logic [3:0]   s_mem  [N];
  logic [W-1:0] a_mem  [N];
  logic [W-1:0] acc_mem[N];
  logic [W-1:0] exp_acc[N];

  int n_chk = 0, n_pass = 0;
  int done_e, busy_n, done_n;

  schoolbook_mac_ctrl #(.N(N), .LOG2N(LOG2N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .s_rd_en(s_rd_en), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
    .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
    .mac_ri(mac_ri), .mac_a(mac_a), .mac_s(mac_s), .mac_result(mac_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s_rd_en)   s_rd_data   <= s_mem[s_rd_addr];
    if (a_rd_en)   a_rd_data   <= a_mem[a_rd_addr];
    if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];
    if (acc_wr_en) acc_mem[acc_wr_addr] <= acc_wr_data;
  end

  function automatic logic [W-1:0] mac_fn(input logic [W-1:0] ri, input logic [W-1:0] a,
                                          input logic [3:0] s);
    logic [2:0] m;
    logic [W-1:0] p;
    m = (s[2:0] > 3'd5) ? 3'd5 : s[2:0];
    p = a * W'(m);
    return s[3] ? ri - p : ri + p;
  endfunction

  assign mac_result = mac_fn(mac_ri, mac_a, mac_s);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic load(input logic [3:0] s0, s1, s2, s3, input logic [W-1:0] a0, a1, a2, a3);
    @(negedge clk);
    s_mem[0] = s0; s_mem[1] = s1; s_mem[2] = s2; s_mem[3] = s3;
    a_mem[0] = a0; a_mem[1] = a1; a_mem[2] = a2; a_mem[3] = a3;
    for (int k = 0; k < N; k++) acc_mem[k] = W'(1234 + 17 * k);
  endtask

  // Edge 0 accepts start; sample at the negedge before edge e to see the level present at edge e.
  task automatic do_run(input bit hold, output int de, output int bn, output int dn);
    de = -1; bn = 0; dn = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      if (busy) bn++;
      if (done) begin
        dn++;
        if (de < 0) de = e;
      end
      if (e == 22) start = 1'b0;
    end
  endtask

  task automatic chk_acc(input string tag, input logic [W-1:0] e0, e1, e2, e3);
    chk({tag, "_acc0"}, 64'(acc_mem[0]), 64'(e0));
    chk({tag, "_acc1"}, 64'(acc_mem[1]), 64'(e1));
    chk({tag, "_acc2"}, 64'(acc_mem[2]), 64'(e2));
    chk({tag, "_acc3"}, 64'(acc_mem[3]), 64'(e3));
  endtask

  task automatic golden();
    logic [W-1:0] p;
    int m;
    for (int k = 0; k < N; k++) exp_acc[k] = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        m = int'(s_mem[i][2:0]);
        if (m > 5) m = 5;
        p = W'(int'(a_mem[j]) * m);
        if (s_mem[i][3] ^ (i + j >= N)) exp_acc[(i + j) % N] = exp_acc[(i + j) % N] - p;
        else                             exp_acc[(i + j) % N] = exp_acc[(i + j) % N] + p;
      end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, done, s_rd_en, s_rd_addr, a_rd_en, a_rd_addr, acc_rd_en, acc_rd_addr,
                acc_wr_en, acc_wr_addr, acc_wr_data, mac_ri, mac_a, mac_s});
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("reset_outputs", outs(), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    load(4'b0001, 4'b0000, 4'b0000, 4'b0000, 13'd1, 13'd2, 13'd3, 13'd4);
    do_run(1'b0, done_e, busy_n, done_n);
    chk("t1_done_edge", 64'(done_e), 64'd22);
    chk("t1_busy_edges", 64'(busy_n), 64'd21);
    chk("t1_done_pulses", 64'(done_n), 64'd1);
    chk_acc("t1", 13'd1, 13'd2, 13'd3, 13'd4);

    load(4'b0000, 4'b0001, 4'b0000, 4'b0000, 13'd1, 13'd2, 13'd3, 13'd4);
    do_run(1'b0, done_e, busy_n, done_n);
    chk_acc("t2", 13'd8188, 13'd1, 13'd2, 13'd3);

    load(4'b1101, 4'b0000, 4'b0000, 4'b0000, 13'd8191, 13'd8191, 13'd8191, 13'd8191);
    do_run(1'b0, done_e, busy_n, done_n);
    chk_acc("t3", 13'd5, 13'd5, 13'd5, 13'd5);

    load(4'b0000, 4'b0000, 4'b0000, 4'b0000, 13'd9, 13'd8, 13'd7, 13'd6);
    do_run(1'b0, done_e, busy_n, done_n);
    chk_acc("zero_digits", 13'd0, 13'd0, 13'd0, 13'd0);

    load(4'b0111, 4'b0000, 4'b0000, 4'b0000, 13'd1, 13'd2, 13'd3, 13'd4);
    do_run(1'b0, done_e, busy_n, done_n);
    chk_acc("mag7_as5", 13'd5, 13'd10, 13'd15, 13'd20);

    load(4'b0000, 4'b0001, 4'b0000, 4'b0000, 13'd1, 13'd2, 13'd3, 13'd4);
    do_run(1'b1, done_e, busy_n, done_n);
    chk("t4a_done_edge", 64'(done_e), 64'd22);
    chk("t4a_busy_edges", 64'(busy_n), 64'd21);
    chk("t4a_done_pulses", 64'(done_n), 64'd1);
    chk_acc("t4a", 13'd8188, 13'd1, 13'd2, 13'd3);
    load(4'b0001, 4'b0000, 4'b0000, 4'b0000, 13'd1, 13'd2, 13'd3, 13'd4);
    do_run(1'b0, done_e, busy_n, done_n);
    chk("t4b_done_edge", 64'(done_e), 64'd22);
    chk("t4b_done_pulses", 64'(done_n), 64'd1);
    chk_acc("t4b", 13'd1, 13'd2, 13'd3, 13'd4);

    load(4'b0001, 4'b0010, 4'b1011, 4'b0100, 13'd100, 13'd200, 13'd300, 13'd400);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("t5_busy_before_rst", 64'(busy), 64'd1);
    chk("t5_run_before_rst", 64'(a_rd_en), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("t5_outputs_in_rst", outs(), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    load(4'b0000, 4'b0001, 4'b0000, 4'b0000, 13'd1, 13'd2, 13'd3, 13'd4);
    do_run(1'b0, done_e, busy_n, done_n);
    chk("t5_done_edge", 64'(done_e), 64'd22);
    chk_acc("t5", 13'd8188, 13'd1, 13'd2, 13'd3);

    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        s_mem[k]   = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 5))};
        a_mem[k]   = W'($urandom);
        acc_mem[k] = W'($urandom);
      end
      golden();
      do_run(1'b0, done_e, busy_n, done_n);
      for (int k = 0; k < N; k++) chk($sformatf("rand%0d_acc%0d", r, k), 64'(acc_mem[k]), 64'(exp_acc[k]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
